// File: rtl/signed_mult_scroll_display.sv
// Signed sequential multiplier with double-dabble BCD conversion and a
// scrollable, multiplexed 7-segment display (sign position plus DIGITS digits).
module signed_mult_scroll_display #(
  parameter int W        = 8,
  parameter int ND       = 5,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [W-1:0]      mp,
  input  logic [W-1:0]      mc,
  input  logic              btn_left,
  input  logic              btn_right,
  output logic              busy,
  output logic              done,
  output logic [2*W-1:0]    product,
  output logic [6:0]        segments,
  output logic [DIGITS:0]   anode_active
);

  localparam int PW = 2*W - 1;
  localparam int CW = $clog2(2*W + 1);
  localparam int OW = $clog2(ND + 1);
  localparam int SW = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {IDLE, MULT, BCD, SHOW} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [W-1:0]         mpl_q;
  logic [PW-1:0]        mcd_q, acc_q, acc_d;
  logic                 sign_q, neg_q, busy_q, done_q;
  logic [4*ND+PW-1:0]   dd_q, dd_adj, dd_d;
  logic [4*ND-1:0]      disp_q;
  logic [2*W-1:0]       product_q, mag_ext;
  logic [OW-1:0]        off_q;
  logic [SCAN_DIV-1:0]  presc_q;
  logic [SW-1:0]        scan_q;
  logic [6:0]           seg_q, seg_d;
  logic [DIGITS:0]      an_q, an_d;
  logic [W-1:0]         amp, amc;
  logic                 accept;
  logic                 neg_res;
  int unsigned          msd, idx;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b0000001;
      4'd1:    glyph = 7'b1001111;
      4'd2:    glyph = 7'b0010010;
      4'd3:    glyph = 7'b0000110;
      4'd4:    glyph = 7'b1001100;
      4'd5:    glyph = 7'b0100100;
      4'd6:    glyph = 7'b0100000;
      4'd7:    glyph = 7'b0001111;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0000100;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    accept  = start && (state_q == IDLE || state_q == SHOW);
    amp     = mp[W-1] ? (~mp + 1'b1) : mp;
    amc     = mc[W-1] ? (~mc + 1'b1) : mc;
    acc_d   = acc_q + (mpl_q[0] ? mcd_q : '0);
    mag_ext = {1'b0, acc_q};
    neg_res = sign_q && (acc_q != '0);
    dd_adj  = dd_q;
    for (int unsigned i = 0; i < ND; i++) begin
      if (dd_adj[PW+4*i +: 4] >= 4'd5)
        dd_adj[PW+4*i +: 4] = dd_adj[PW+4*i +: 4] + 4'd3;
    end
    dd_d = {dd_adj[4*ND+PW-2:0], 1'b0};
  end

  // BCD lasts 2W cycles: 2W-1 shift steps, then a commit cycle that raises done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mpl_q     <= '0;
      mcd_q     <= '0;
      acc_q     <= '0;
      sign_q    <= 1'b0;
      dd_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      disp_q    <= '0;
      neg_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MULT: begin
          acc_q <= acc_d;
          mpl_q <= mpl_q >> 1;
          mcd_q <= mcd_q << 1;
          if (cnt_q == CW'(W-1)) begin
            cnt_q   <= '0;
            dd_q    <= {{(4*ND){1'b0}}, acc_d};
            state_q <= BCD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BCD: begin
          if (cnt_q == CW'(PW)) begin
            state_q   <= SHOW;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            disp_q    <= dd_q[4*ND+PW-1:PW];
            neg_q     <= neg_res;
            product_q <= neg_res ? (~mag_ext + 1'b1) : mag_ext;
          end else begin
            dd_q  <= dd_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          if (accept) begin
            state_q <= MULT;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            mpl_q   <= amp;
            mcd_q   <= {{(W-1){1'b0}}, amc};
            acc_q   <= '0;
            sign_q  <= mp[W-1] ^ mc[W-1];
          end
        end
      endcase
    end
  end

  always_comb begin
    msd = 0;
    for (int unsigned i = 0; i < ND; i++) begin
      if (disp_q[4*i +: 4] != 4'd0) msd = i;
    end
    idx  = 32'(off_q) + 32'(scan_q);
    an_d = '1;
    an_d[scan_q] = 1'b0;
    if (scan_q == SW'(DIGITS))
      seg_d = neg_q ? 7'b1111110 : 7'b1111111;
    else if (idx > msd)
      seg_d = 7'b1111111;
    else
      seg_d = glyph(disp_q[4*idx +: 4]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      off_q   <= '0;
      presc_q <= '0;
      scan_q  <= '0;
      seg_q   <= '1;
      an_q    <= {{DIGITS{1'b1}}, 1'b0};
    end else begin
      if (accept)
        off_q <= '0;
      else if (btn_left && !btn_right && off_q < OW'(ND-DIGITS))
        off_q <= off_q + 1'b1;
      else if (btn_right && !btn_left && off_q != '0)
        off_q <= off_q - 1'b1;
      presc_q <= presc_q + 1'b1;
      if (presc_q == '1)
        scan_q <= (scan_q == SW'(DIGITS)) ? '0 : scan_q + 1'b1;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign product      = product_q;
  assign segments     = seg_q;
  assign anode_active = an_q;

endmodule

// File: tb/tb_signed_mult_scroll_display.sv
// Directed bench for signed_mult_scroll_display (W=8, ND=5, DIGITS=3, fast scan).
module tb_signed_mult_scroll_display;

  localparam logic [6:0] G0 = 7'h01, G1 = 7'h4F, G2 = 7'h12, G3 = 7'h06, G4 = 7'h4C;
  localparam logic [6:0] G5 = 7'h24, G6 = 7'h20, G8 = 7'h00, G9 = 7'h04;
  localparam logic [6:0] BL = 7'h7F, MI = 7'h7E;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    logic [6:0]  sg, p0, p1, p2;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, start, btn_left, btn_right;
  logic [7:0]  mp, mc;
  logic        busy, done;
  logic [15:0] product;
  logic [6:0]  segments;
  logic [3:0]  anode_active;

  int total = 0;
  int bad   = 0;
  vec_t tv[7];

  signed_mult_scroll_display #(.W(8), .ND(5), .DIGITS(3), .SCAN_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mp(mp), .mc(mc),
    .btn_left(btn_left), .btn_right(btn_right), .busy(busy), .done(done),
    .product(product), .segments(segments), .anode_active(anode_active)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic read_pos(input int pos, output logic [6:0] s);
    logic [3:0] want;
    bit ok;
    want = '1;
    want[pos] = 1'b0;
    ok = 0;
    s = 'x;
    for (int k = 0; k < 24 && !ok; k++) begin
      @(negedge clk);
      if (anode_active == want) begin
        s = segments;
        ok = 1;
      end
    end
    if (!ok) chk("scan_timeout", 32'(anode_active), 32'(want));
  endtask

  task automatic check_disp(input string nm, input logic [6:0] sg, input logic [6:0] e0,
                            input logic [6:0] e1, input logic [6:0] e2);
    logic [6:0] s;
    read_pos(3, s); chk({nm, "_sign"}, 32'(s), 32'(sg));
    read_pos(0, s); chk({nm, "_pos0"}, 32'(s), 32'(e0));
    read_pos(1, s); chk({nm, "_pos1"}, 32'(s), 32'(e1));
    read_pos(2, s); chk({nm, "_pos2"}, 32'(s), 32'(e2));
  endtask

  task automatic run_mult(input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    mp = a; mc = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("done_latency", 32'(lat), 32'd24);
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask

  task automatic pulse(input logic l, input logic r);
    @(negedge clk);
    btn_left = l; btn_right = r;
    @(negedge clk);
    btn_left = 1'b0; btn_right = 1'b0;
  endtask

  initial begin
    int lat, cur, run;
    bit seen;
    logic [3:0] prev, want;
    logic [6:0] s;

    tv[0] = '{8'd7,    8'hFD, 16'hFFEB, MI, G1, G2, BL};
    tv[1] = '{8'h80,   8'h80, 16'h4000, BL, G4, G8, G3};
    tv[2] = '{8'd0,    8'hFB, 16'h0000, BL, G0, BL, BL};
    tv[3] = '{8'd127,  8'd127, 16'h3F01, BL, G9, G2, G1};
    tv[4] = '{8'hFF,   8'd1,  16'hFFFF, MI, G1, BL, BL};
    tv[5] = '{8'h80,   8'd127, 16'hC080, MI, G6, G5, G2};
    tv[6] = '{8'd100,  8'h9C, 16'hD8F0, MI, G0, G0, G0};

    rst_n = 1'b0; start = 1'b0; btn_left = 1'b0; btn_right = 1'b0; mp = '0; mc = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_anode", 32'(anode_active), 32'hE);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_anode", 32'(anode_active), 32'hE);
    chk("first_seg", 32'(segments), 32'(G0));

    // scan order and period: one anode low, advancing every 4 cycles
    prev = anode_active; cur = 0; run = 1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      chk("scan_onehot", 32'($countones(~anode_active)), 32'd1);
      if (anode_active != prev) begin
        want = '1;
        want[(cur + 1) % 4] = 1'b0;
        chk("scan_order", 32'(anode_active), 32'(want));
        chk("scan_period", 32'(run), 32'd4);
        cur = (cur + 1) % 4; run = 1; prev = anode_active;
      end else begin
        run++;
      end
    end

    for (int i = 0; i < 7; i++) begin
      run_mult(tv[i].a, tv[i].b, lat);
      chk("product", 32'(product), 32'(tv[i].prod));
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      check_disp("vec", tv[i].sg, tv[i].p0, tv[i].p1, tv[i].p2);
    end

    // scrolling across 16384 with saturation at both ends
    run_mult(8'h80, 8'h80, lat);
    pulse(1'b1, 1'b0); pulse(1'b1, 1'b0);
    check_disp("scroll2", BL, G3, G6, G1);
    pulse(1'b1, 1'b0);
    check_disp("scroll_sat_hi", BL, G3, G6, G1);
    pulse(1'b1, 1'b1);
    check_disp("scroll_both", BL, G3, G6, G1);
    pulse(1'b0, 1'b1);
    check_disp("scroll1", BL, G8, G3, G6);
    pulse(1'b0, 1'b1); pulse(1'b0, 1'b1); pulse(1'b0, 1'b1);
    check_disp("scroll_sat_lo", BL, G4, G8, G3);

    // start during MULT must be ignored
    @(negedge clk);
    mp = 8'd7; mc = 8'hFD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (k == 4) begin
        start = 1'b1; mp = 8'd5; mc = 8'd5;
      end
      if (k == 5) start = 1'b0;
    end
    chk("ignored_start_latency", 32'(lat), 32'd24);
    chk("ignored_start_product", 32'(product), 32'hFFEB);

    // reset during MULT aborts with no done pulse
    @(negedge clk);
    mp = 8'd3; mc = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_product", 32'(product), 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    check_disp("abort_disp", BL, G0, BL, BL);
    run_mult(8'hFF, 8'd1, lat);
    chk("post_abort_product", 32'(product), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
